idct_block_sched: RTL and testbench

- Input-side scheduler for the idct_top 2-D IDCT pipeline.
- Accepts coefficient samples from an upstream valid/ready stream and assembles them into 8x8 blocks in a two-bank ping-pong buffer.
- Replays each complete block to idct_top as 64 contiguous samples with the correct idct control code.
- Re-times the pipeline result into a framed output stream using a delayed copy of the control code.

---
 rtl/idct_block_sched.sv | 208 ++++++++++++++++++++
 tb/tb_idct_block_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_block_sched.sv
// idct_block_sched: ping-pong 8x8 block buffer feeding idct_top, plus result re-timing.
// Build with IDCT_GAP_EN defined to force GAP_CYCLES idle codes between issued blocks.
module idct_block_sched #(
    parameter int WIDTH_X    = 16,
    parameter int PIPE_LAT   = 140,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH_X-1:0] s_data,
    output logic [1:0]         idct,
    output logic [WIDTH_X-1:0] x_out,
    input  logic [WIDTH_X-1:0] z_in,
    output logic               m_valid,
    output logic [WIDTH_X-1:0] m_data,
    output logic               m_first,
    output logic               m_last,
    output logic [15:0]        blk_done,
    output logic               busy
);

    if (PIPE_LAT < 1 || PIPE_LAT > 255) begin : g_badLat
        $error("PIPE_LAT must be within 1..255");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_badGap
        $error("GAP_CYCLES must be within 1..15");
    end

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
`ifdef IDCT_GAP_EN
    localparam logic [1:0] ST_GAP     = 2'd2;
`endif

    localparam logic [1:0] CODE_IDLE  = 2'b00;
    localparam logic [1:0] CODE_FIRST = 2'b01;
    localparam logic [1:0] CODE_MID   = 2'b10;
    localparam logic [1:0] CODE_LAST  = 2'b11;

    logic [WIDTH_X-1:0] mem_q [128];

    logic [1:0]         full_q, full_d;
    logic               wrBank_q, wrBank_d;
    logic [5:0]         wrCnt_q, wrCnt_d;
    logic               rdBank_q, rdBank_d;
    logic [5:0]         rdCnt_q, rdCnt_d;
    logic [1:0]         state_q, state_d;
    logic [1:0]         idct_q, idct_d;
    logic [WIDTH_X-1:0] xOut_q, xOut_d;
`ifdef IDCT_GAP_EN
    logic [3:0]         gapCnt_q, gapCnt_d;
`else
    logic               otherReady;
`endif

    logic [1:0]         dl_q [PIPE_LAT];
    logic [1:0]         tap;
    logic               dlAny;
    logic               mValid_q, mFirst_q, mLast_q;
    logic [WIDTH_X-1:0] mData_q;
    logic [15:0]        blkDone_q;

    logic               accept, wrDone, rdDone;

    // Gating with rst_n keeps s_ready low while reset is held.
    assign s_ready = rst_n & ~full_q[wrBank_q];
    assign accept  = s_valid & s_ready;
    assign wrDone  = accept & (wrCnt_q == 6'd63);
    assign rdDone  = (state_q == ST_ISSUE) & (rdCnt_q == 6'd63);
`ifndef IDCT_GAP_EN
    // A block completing on this very clock still counts, so continuous input never bubbles.
    assign otherReady = full_q[~rdBank_q] | (wrDone & (wrBank_q == ~rdBank_q));
`endif

    always_ff @(posedge clk) begin
        if (accept) mem_q[{wrBank_q, wrCnt_q}] <= s_data;
    end

    always_comb begin
        wrCnt_d  = wrCnt_q;
        wrBank_d = wrBank_q;
        full_d   = full_q;
        if (accept) begin
            wrCnt_d = wrCnt_q + 6'd1;
            if (wrDone) wrBank_d = ~wrBank_q;
        end
        if (wrDone) full_d[wrBank_q] = 1'b1;
        if (rdDone) full_d[rdBank_q] = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        rdCnt_d  = rdCnt_q;
        rdBank_d = rdBank_q;
        idct_d   = CODE_IDLE;
        xOut_d   = '0;
`ifdef IDCT_GAP_EN
        gapCnt_d = gapCnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (full_q[rdBank_q]) begin
                    state_d = ST_ISSUE;
                    rdCnt_d = 6'd0;
                end
            end
            ST_ISSUE: begin
                xOut_d  = mem_q[{rdBank_q, rdCnt_q}];
                idct_d  = (rdCnt_q == 6'd0)  ? CODE_FIRST :
                          (rdCnt_q == 6'd63) ? CODE_LAST  : CODE_MID;
                rdCnt_d = rdCnt_q + 6'd1;
                if (rdDone) begin
                    rdBank_d = ~rdBank_q;
`ifdef IDCT_GAP_EN
                    state_d  = ST_GAP;
                    gapCnt_d = 4'd0;
`else
                    state_d  = otherReady ? ST_ISSUE : ST_IDLE;
`endif
                end
            end
`ifdef IDCT_GAP_EN
            // The last gap clock hands straight to ISSUE so exactly GAP_CYCLES idle codes appear.
            ST_GAP: begin
                gapCnt_d = gapCnt_q + 4'd1;
                rdCnt_d  = 6'd0;
                if (gapCnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = full_q[rdBank_q] ? ST_ISSUE : ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            wrBank_q <= 1'b0;
            wrCnt_q  <= '0;
            rdBank_q <= 1'b0;
            rdCnt_q  <= '0;
            state_q  <= ST_IDLE;
            idct_q   <= CODE_IDLE;
            xOut_q   <= '0;
`ifdef IDCT_GAP_EN
            gapCnt_q <= '0;
`endif
        end else begin
            full_q   <= full_d;
            wrBank_q <= wrBank_d;
            wrCnt_q  <= wrCnt_d;
            rdBank_q <= rdBank_d;
            rdCnt_q  <= rdCnt_d;
            state_q  <= state_d;
            idct_q   <= idct_d;
            xOut_q   <= xOut_d;
`ifdef IDCT_GAP_EN
            gapCnt_q <= gapCnt_d;
`endif
        end
    end

    // Delay line mirrors idct_top latency so the code lines up with z_in at the tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= CODE_IDLE;
        end else begin
            dl_q[0] <= idct_q;
            for (int i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign tap = dl_q[PIPE_LAT-1];

    always_comb begin
        dlAny = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) dlAny = dlAny | (dl_q[i] != CODE_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mValid_q  <= 1'b0;
            mFirst_q  <= 1'b0;
            mLast_q   <= 1'b0;
            mData_q   <= '0;
            blkDone_q <= '0;
        end else begin
            mValid_q  <= (tap != CODE_IDLE);
            mFirst_q  <= (tap == CODE_FIRST);
            mLast_q   <= (tap == CODE_LAST);
            mData_q   <= z_in;
            if (tap == CODE_LAST) blkDone_q <= blkDone_q + 16'd1;
        end
    end

    assign idct     = idct_q;
    assign x_out    = xOut_q;
    assign m_valid  = mValid_q;
    assign m_data   = mData_q;
    assign m_first  = mFirst_q;
    assign m_last   = mLast_q;
    assign blk_done = blkDone_q;
    assign busy     = (|full_q) | (state_q != ST_IDLE) | (idct_q != CODE_IDLE) | dlAny;

endmodule

// File: tb/tb_idct_block_sched.sv
// Directed bench for idct_block_sched; z_in comes from a fixed-latency stand-in for idct_top.
// Honours IDCT_GAP_EN when computing the expected spacing between blocks.
module tb_idct_block_sched;

    localparam int W      = 16;
    localparam int TB_LAT = 140;
    localparam int TB_GAP = 2;
`ifdef IDCT_GAP_EN
    localparam int EXP_STRIDE = TB_GAP + 1;
`else
    localparam int EXP_STRIDE = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic [1:0]   idct;
    logic [W-1:0] x_out;
    logic [W-1:0] z_in;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_first;
    logic         m_last;
    logic [15:0]  blk_done;
    logic         busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int idleXErr = 0;
    int accEdge[$];
    int issCyc[$];
    int issCode[$];
    int issData[$];
    int outCyc[$];
    int outData[$];
    int outFirst[$];
    int outLast[$];
    logic [W-1:0] zPipe [TB_LAT];

    typedef struct {
        int nBlocks;
        bit bursty;
        int base;
        int expValid;
        int expFirst;
        int expLast;
        int expDone;
    } vec_t;

    vec_t vecs[4];

    idct_block_sched #(
        .WIDTH_X(W),
        .PIPE_LAT(TB_LAT),
        .GAP_CYCLES(TB_GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .idct(idct),
        .x_out(x_out),
        .z_in(z_in),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_first(m_first),
        .m_last(m_last),
        .blk_done(blk_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for idct_top: a pure TB_LAT-clock delay with a recognisable XOR applied.
    initial for (int i = 0; i < TB_LAT; i++) zPipe[i] = '0;
    always @(posedge clk) begin
        zPipe[0] <= x_out ^ 16'h5A5A;
        for (int i = 1; i < TB_LAT; i++) zPipe[i] <= zPipe[i-1];
    end
    assign z_in = zPipe[TB_LAT-1];

    always @(negedge clk) begin
        if (idct != 2'b00) begin
            issCyc.push_back(cyc);
            issCode.push_back(int'(idct));
            issData.push_back(int'(x_out));
        end else if (x_out != '0) begin
            idleXErr++;
        end
        if (m_valid) begin
            outCyc.push_back(cyc);
            outData.push_back(int'(m_data));
            outFirst.push_back(int'(m_first));
            outLast.push_back(int'(m_last));
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clearLogs();
        accEdge.delete();
        issCyc.delete();
        issCode.delete();
        issData.delete();
        outCyc.delete();
        outData.delete();
        outFirst.delete();
        outLast.delete();
        idleXErr = 0;
    endtask

    task automatic doReset();
        s_valid = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
    endtask

    // Offers n samples base, base+1, ...; bursty mode randomly drops s_valid.
    task automatic applyStimulus(input int n, input int base, input bit bursty);
        int sent = 0;
        int waitCyc = 0;
        while (sent < n && waitCyc < 3000) begin
            @(posedge clk);
            #1;
            s_valid = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = W'(base + sent);
            if (s_valid && s_ready) begin
                accEdge.push_back(cyc + 1);
                sent++;
                waitCyc = 0;
            end else begin
                waitCyc++;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        checkOutput("accept_count", sent, n);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput({tag, "_drain_busy"}, busy, 0);
    endtask

    task automatic checkStreams(input string tag, input int nBlk, input int base, input bit bursty);
        int errI = 0;
        int errO = 0;
        int errG = 0;
        int n = nBlk * 64;
        checkOutput({tag, "_iss_count"}, issCode.size(), n);
        checkOutput({tag, "_out_count"}, outCyc.size(), n);
        if (issCode.size() == n && outCyc.size() == n && accEdge.size() >= 64) begin
            for (int i = 0; i < n; i++) begin
                int j = i % 64;
                int expCode = (j == 0) ? 1 : ((j == 63) ? 3 : 2);
                int d;
                if (issCode[i] != expCode || issData[i] != ((base + i) & 16'hFFFF)) errI++;
                if (j != 0 && issCyc[i] != issCyc[i-1] + 1) errI++;
                if (outData[i] != (((base + i) & 16'hFFFF) ^ 16'h5A5A)) errO++;
                if (outFirst[i] != int'(j == 0) || outLast[i] != int'(j == 63)) errO++;
                if (j != 0 && outCyc[i] != outCyc[i-1] + 1) errO++;
                if (j == 0 && i != 0) begin
                    d = issCyc[i] - issCyc[i-1];
                    if (bursty ? (d < EXP_STRIDE) : (d != EXP_STRIDE)) errG++;
                    d = outCyc[i] - outCyc[i-1];
                    if (bursty ? (d < EXP_STRIDE) : (d != EXP_STRIDE)) errG++;
                end
            end
            checkOutput({tag, "_issue_latency"}, issCyc[0] - accEdge[63], 2);
            checkOutput({tag, "_first_latency"}, outCyc[0] - issCyc[0], TB_LAT + 1);
        end else begin
            errI = -1;
            errO = -1;
        end
        checkOutput({tag, "_issue_stream_errs"}, errI, 0);
        checkOutput({tag, "_out_stream_errs"}, errO, 0);
        checkOutput({tag, "_block_gap_errs"}, errG, 0);
        checkOutput({tag, "_idle_x_nonzero"}, idleXErr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sumF;
        int sumL;
        string tag;

        vecs[0] = '{nBlocks: 1, bursty: 1'b0, base: 0,     expValid: 64,  expFirst: 1, expLast: 1, expDone: 1};
        vecs[1] = '{nBlocks: 4, bursty: 1'b0, base: 100,   expValid: 256, expFirst: 4, expLast: 4, expDone: 4};
        vecs[2] = '{nBlocks: 2, bursty: 1'b0, base: 65504, expValid: 128, expFirst: 2, expLast: 2, expDone: 2};
        vecs[3] = '{nBlocks: 3, bursty: 1'b1, base: 1000,  expValid: 192, expFirst: 3, expLast: 3, expDone: 3};

        // Outputs while reset is held, then right after release.
        #12;
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_idct", idct, 0);
        checkOutput("rst_x_out", x_out, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_first", m_first, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_blk_done", blk_done, 0);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        #1;
        checkOutput("post_rst_s_ready", s_ready, 1);
        checkOutput("post_rst_busy", busy, 0);

        for (int v = 0; v < 4; v++) begin
            tag = $sformatf("v%0d", v);
            doReset();
            applyStimulus(vecs[v].nBlocks * 64, vecs[v].base, vecs[v].bursty);
            waitIdle(tag);
            sumF = 0;
            sumL = 0;
            foreach (outFirst[i]) sumF += outFirst[i];
            foreach (outLast[i]) sumL += outLast[i];
            checkOutput({tag, "_m_valid_count"}, outCyc.size(), vecs[v].expValid);
            checkOutput({tag, "_m_first_count"}, sumF, vecs[v].expFirst);
            checkOutput({tag, "_m_last_count"}, sumL, vecs[v].expLast);
            checkOutput({tag, "_blk_done"}, blk_done, vecs[v].expDone);
            checkStreams(tag, vecs[v].nBlocks, vecs[v].base, vecs[v].bursty);
        end

        // Backpressure: both banks full, sample 129 waits for the first block's last issue.
        doReset();
        applyStimulus(128, 0, 1'b0);
        checkOutput("bp_ready_low_at_129", s_ready, 0);
        applyStimulus(1, 128, 1'b0);
        if (accEdge.size() == 129 && issCyc.size() >= 64) begin
            checkOutput("bp_accept_on_last_issue", accEdge[128] - issCyc[63], 1);
            checkOutput("bp_code_before_accept", issCode[63], 3);
        end else begin
            checkOutput("bp_log_size", issCyc.size(), 64);
        end
        applyStimulus(63, 129, 1'b0);
        waitIdle("bp");
        checkStreams("bp", 3, 0, 1'b1);
        checkOutput("bp_blk_done", blk_done, 3);

        // Reset in the middle of the second block while the first is still issuing.
        doReset();
        applyStimulus(64, 0, 1'b0);
        applyStimulus(30, 64, 1'b0);
        checkOutput("mid_issuing_before_rst", int'(idct != 2'b00), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_idct", idct, 0);
        checkOutput("mid_rst_x_out", x_out, 0);
        checkOutput("mid_rst_m_valid", m_valid, 0);
        checkOutput("mid_rst_blk_done", blk_done, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_s_ready", s_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clearLogs();
        #1;
        checkOutput("mid_post_s_ready", s_ready, 1);
        checkOutput("mid_post_busy", busy, 0);
        repeat (TB_LAT + 80) @(negedge clk);
        checkOutput("mid_post_no_m_valid", outCyc.size(), 0);
        checkOutput("mid_post_no_issue", issCyc.size(), 0);
        applyStimulus(64, 500, 1'b0);
        waitIdle("fresh");
        checkStreams("fresh", 1, 500, 1'b0);
        checkOutput("fresh_blk_done", blk_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
